// File: rtl/car_pkg.sv
// Shared types and constants for the car wave controller.
package car_pkg;

  // Draw-chain sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } car_state_e;

  // err_flags bit positions: {overrun, wren_conflict, draw_timeout}.
  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_CONFLICT = 1;
  localparam int ERR_OVERRUN  = 2;
  localparam int ERR_W        = 3;

  // Spawn delays for 4 cars x (3 stages + default row), 8 bits each.
  // Row r, car i lives at [(r*4+i)*8 +: 8]; rows listed default..stage0.
  localparam logic [127:0] CAR_STAGE_DELAYS_DEFAULT = {
    32'hF0E0_C080,  // default: 80,C0,E0,F0
    32'hC0C0_C080,  // stage2 : 80,C0,C0,C0
    32'hF0E0_C080,  // stage1 : 80,C0,E0,F0
    32'hFFE0_C080   // stage0 : 80,C0,E0,FF
  };

endpackage

// File: rtl/car_wave_ctrl_if.sv
// Registered VGA write port shared by all car instances.
interface car_wave_ctrl_if #(
  parameter int COORD_W  = 15,
  parameter int COLOUR_W = 9
);
  logic                wren;
  logic [COORD_W-1:0]  coord;
  logic [COLOUR_W-1:0] colour;

  modport master (output wren, coord, colour);
  modport slave  (input  wren, coord, colour);
endinterface

// File: rtl/car_vga_arbiter.sv
// Fixed-priority VGA write mux: lowest-index writer wins, one cycle latency.
module car_vga_arbiter #(
  parameter int NUM_CARS = 4,
  parameter int COORD_W  = 15,
  parameter int COLOUR_W = 9
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CARS-1:0]          wren_in,
  input  logic [NUM_CARS*COORD_W-1:0]  coord_in,
  input  logic [NUM_CARS*COLOUR_W-1:0] colour_in,
  output logic                         wren,
  output logic [COORD_W-1:0]           coord,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         conflict
);

  logic                wren_d,   wren_q;
  logic [COORD_W-1:0]  coord_d,  coord_q;
  logic [COLOUR_W-1:0] colour_d, colour_q;

  // Pick the winning writer; scanning high-to-low leaves the lowest index last.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a variable unassigned (no latch).
    wren_d   = 1'b0;
    coord_d  = '0;
    colour_d = '0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      if (wren_in[i]) begin
        wren_d   = 1'b1;
        coord_d  = coord_in[i*COORD_W +: COORD_W];
        colour_d = colour_in[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign conflict = |(wren_in & (wren_in - NUM_CARS'(1)));

  // Output register for the shared write port.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    if (resetn) begin
      wren_q   <= 1'b0;
      coord_q  <= '0;
      colour_q <= '0;
    end else begin
      wren_q   <= wren_d;
      coord_q  <= coord_d;
      colour_q <= colour_d;
    end
  end

  assign wren   = wren_q;
  assign coord  = coord_q;
  assign colour = colour_q;

endmodule

// File: rtl/car_wave_ctrl.sv
// Wave controller: draw-chain sequencer, spawn-delay select, status tracking.
module car_wave_ctrl
  import car_pkg::*;
#(
  parameter int NUM_CARS   = 4,
  parameter int NUM_STAGES = 3,
  parameter int COORD_W    = 15,
  parameter int COLOUR_W   = 9,
  parameter int DELAY_W    = 8,
  parameter int TIMEOUT_W  = 16,
  parameter logic [(NUM_STAGES+1)*NUM_CARS*DELAY_W-1:0] STAGE_DELAYS =
    CAR_STAGE_DELAYS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         resetn,  // active-high despite the name
  input  logic [NUM_STAGES-1:0]        stage_in_progress,
  input  logic                         start_frame,
  input  logic [NUM_CARS-1:0]          car_destroyed,
  input  logic [NUM_CARS-1:0]          car_done,
  input  logic [NUM_CARS-1:0]          car_erase_done,
  input  logic [NUM_CARS-1:0]          car_game_over,
  input  logic [NUM_CARS-1:0]          car_wren_in,
  input  logic [NUM_CARS*COORD_W-1:0]  car_coord_in,
  input  logic [NUM_CARS*COLOUR_W-1:0] car_colour_in,
  output logic                         car_initiate,
  output logic [NUM_CARS-1:0]          car_enable_draw,
  output logic [NUM_CARS*DELAY_W-1:0]  car_delay_frames,
  car_wave_ctrl_if.master              vga,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         wave_done,
  output logic                         game_over_feedback,
  output logic [ERR_W-1:0]             err_flags
);

  localparam int IDX_W = $clog2(NUM_CARS + 1);
  localparam int ROW_W = NUM_CARS * DELAY_W;

  car_state_e           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [NUM_CARS-1:0]  enable_q;
  logic                 frame_done_q, busy_q;

  logic [NUM_CARS-1:0]  dest_d, dest_q, erased_d, erased_q;
  logic                 init_d, init_q, wave_done_d, wave_done_q;
  logic                 game_over_d, game_over_q;
  logic [ERR_W-1:0]     err_d, err_q;
  logic [ROW_W-1:0]     delay_d, delay_q, stage_row;

  logic [NUM_CARS-1:0]  sel_onehot, retired;
  logic                 done_sel, timeout_hit, accept, overrun, clear, conflict;

  assign sel_onehot  = NUM_CARS'(1) << idx_q;   // all-zero once idx == NUM_CARS
  assign retired     = dest_q & erased_q;
  assign done_sel    = |(car_done & sel_onehot);
  assign timeout_hit = (state_q == S_WAIT) && !done_sel &&
                       ((wd_q + TIMEOUT_W'(1)) == {TIMEOUT_W{1'b1}});
  assign accept      = (state_q == S_IDLE) && start_frame;
  assign overrun     = (state_q != S_IDLE) && start_frame;
  assign clear       = init_q && !init_d;       // car_initiate falling

  // Delay row for the lowest active stage, default row when none is active.
  always_comb begin
    stage_row = STAGE_DELAYS[NUM_STAGES*ROW_W +: ROW_W];
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (stage_in_progress[s]) stage_row = STAGE_DELAYS[s*ROW_W +: ROW_W];
    end
  end

  // Draw-chain sequencer with registered enable/frame_done/busy outputs.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      wd_q         <= '0;
      enable_q     <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      enable_q     <= '0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_frame) begin
          state_q <= S_SELECT;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        S_SELECT: begin
          if (idx_q == IDX_W'(NUM_CARS)) begin
            state_q      <= S_DONE;
            frame_done_q <= 1'b1;
          end else if (|(retired & sel_onehot)) begin
            idx_q <= idx_q + IDX_W'(1);
          end else begin
            state_q  <= S_ISSUE;
            enable_q <= sel_onehot;  // high for the ISSUE cycle only
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_sel || timeout_hit) begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_SELECT;
          end else begin
            wd_q <= wd_q + TIMEOUT_W'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Next-state for sticky status, errors, stage latch and car_initiate.
  always_comb begin
    init_d  = |stage_in_progress;
    delay_d = accept ? stage_row : delay_q;
    if (clear) begin
      dest_d      = '0;
      erased_d    = '0;
      game_over_d = 1'b0;
      err_d       = '0;
    end else begin
      dest_d      = dest_q | car_destroyed;
      erased_d    = erased_q | (car_erase_done & dest_q);
      game_over_d = game_over_q | (|car_game_over);
      err_d       = err_q;
      err_d[ERR_OVERRUN]  = err_q[ERR_OVERRUN]  | overrun;
      err_d[ERR_CONFLICT] = err_q[ERR_CONFLICT] | conflict;
      err_d[ERR_TIMEOUT]  = err_q[ERR_TIMEOUT]  | timeout_hit;
    end
    wave_done_d = &(dest_d & erased_d);
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (resetn) begin
      init_q      <= 1'b0;
      delay_q     <= STAGE_DELAYS[NUM_STAGES*ROW_W +: ROW_W];
      dest_q      <= '0;
      erased_q    <= '0;
      game_over_q <= 1'b0;
      err_q       <= '0;
      wave_done_q <= 1'b0;
    end else begin
      init_q      <= init_d;
      delay_q     <= delay_d;
      dest_q      <= dest_d;
      erased_q    <= erased_d;
      game_over_q <= game_over_d;
      err_q       <= err_d;
      wave_done_q <= wave_done_d;
    end
  end

  logic                arb_wren;
  logic [COORD_W-1:0]  arb_coord;
  logic [COLOUR_W-1:0] arb_colour;

  car_vga_arbiter #(
    .NUM_CARS (NUM_CARS),
    .COORD_W  (COORD_W),
    .COLOUR_W (COLOUR_W)
  ) u_arbiter (
    .clk       (clk),
    .resetn    (resetn),
    .wren_in   (car_wren_in),
    .coord_in  (car_coord_in),
    .colour_in (car_colour_in),
    .wren      (arb_wren),
    .coord     (arb_coord),
    .colour    (arb_colour),
    .conflict  (conflict)
  );

  assign vga.wren           = arb_wren;
  assign vga.coord          = arb_coord;
  assign vga.colour         = arb_colour;
  assign car_initiate       = init_q;
  assign car_enable_draw    = enable_q;
  assign car_delay_frames   = delay_q;
  assign frame_done         = frame_done_q;
  assign busy               = busy_q;
  assign wave_done          = wave_done_q;
  assign game_over_feedback = game_over_q;
  assign err_flags          = err_q;

endmodule

// File: tb/tb_car_wave_ctrl.sv
// Directed bench for car_wave_ctrl (4 cars, 3 stages, 4-bit watchdog).
module tb_car_wave_ctrl;

  localparam int NC = 4;
  localparam int NS = 3;
  localparam int CW = 15;
  localparam int LW = 9;
  localparam int DW = 8;
  localparam int TW = 4;

  localparam logic [31:0] ROW_DEF = 32'hF0E0C080;
  localparam logic [31:0] ROW_S0  = 32'hFFE0C080;
  localparam logic [31:0] ROW_S2  = 32'hC0C0C080;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic [NS-1:0]    stage;
  logic             start_frame;
  logic [NC-1:0]    car_destroyed, car_done, car_erase_done, car_game_over, car_wren_in;
  logic [NC*CW-1:0] car_coord_in;
  logic [NC*LW-1:0] car_colour_in;
  logic             car_initiate;
  logic [NC-1:0]    car_enable_draw;
  logic [NC*DW-1:0] car_delay_frames;
  logic             frame_done, busy, wave_done, game_over_feedback;
  logic [2:0]       err_flags;

  car_wave_ctrl_if #(.COORD_W(CW), .COLOUR_W(LW)) vga ();

  car_wave_ctrl #(
    .NUM_CARS(NC), .NUM_STAGES(NS), .COORD_W(CW), .COLOUR_W(LW),
    .DELAY_W(DW), .TIMEOUT_W(TW)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .stage_in_progress  (stage),
    .start_frame        (start_frame),
    .car_destroyed      (car_destroyed),
    .car_done           (car_done),
    .car_erase_done     (car_erase_done),
    .car_game_over      (car_game_over),
    .car_wren_in        (car_wren_in),
    .car_coord_in       (car_coord_in),
    .car_colour_in      (car_colour_in),
    .car_initiate       (car_initiate),
    .car_enable_draw    (car_enable_draw),
    .car_delay_frames   (car_delay_frames),
    .vga                (vga),
    .frame_done         (frame_done),
    .busy               (busy),
    .wave_done          (wave_done),
    .game_over_feedback (game_over_feedback),
    .err_flags          (err_flags)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
  endtask

  // Wait (bounded) for the next draw enable and compare it.
  task automatic wait_enable(input logic [3:0] exp, input string name);
    logic [3:0] seen;
    bit found;
    seen  = 4'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (car_enable_draw != 4'b0) begin
        found = 1'b1;
        seen  = car_enable_draw;
      end
    end
    total_cnt++;
    if (!found)
      $display("FAIL %s: no car_enable_draw within 40 cycles, expected %b", name, exp);
    else if (seen !== exp)
      $display("FAIL %s: car_enable_draw=%b expected %b", name, seen, exp);
    else
      pass_cnt++;
  endtask

  // Answer n enables in order with car_done, then check frame_done timing.
  task automatic serve_cars(input logic [15:0] seq, input int n, input string name);
    logic [3:0] e;
    for (int k = 0; k < n; k++) begin
      e = seq[k*4 +: 4];
      wait_enable(e, name);
      @(negedge clk);
      total_cnt++;
      if (car_enable_draw !== 4'b0)
        $display("FAIL %s_pulse: car_enable_draw=%b expected 0000", name, car_enable_draw);
      else pass_cnt++;
      car_done = e;
      @(negedge clk);
      car_done = '0;
    end
    total_cnt++;
    if (frame_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s_fd1: frame_done=%b busy=%b expected 0 1", name, frame_done, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b1)
      $display("FAIL %s_fd2: frame_done=%b expected 1", name, frame_done);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (frame_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_fd3: frame_done=%b busy=%b expected 0 0", name, frame_done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    tick(3);
    total_cnt++;
    if ({car_initiate, car_enable_draw, frame_done, busy, wave_done,
         game_over_feedback, err_flags} !== 12'b0)
      $display("FAIL reset_outs: got %b expected all zero",
               {car_initiate, car_enable_draw, frame_done, busy, wave_done,
                game_over_feedback, err_flags});
    else pass_cnt++;
    total_cnt++;
    if ({vga.wren, vga.coord, vga.colour} !== 25'b0)
      $display("FAIL reset_vga: wren=%b coord=%h colour=%h expected 0", vga.wren, vga.coord, vga.colour);
    else pass_cnt++;
    total_cnt++;
    if (car_delay_frames !== ROW_DEF)
      $display("FAIL reset_delay: car_delay_frames=%h expected %h", car_delay_frames, ROW_DEF);
    else pass_cnt++;
    resetn = 1'b0;
    tick(2);
    total_cnt++;
    if (busy !== 1'b0 || car_enable_draw !== 4'b0)
      $display("FAIL reset_idle: busy=%b en=%b expected 0 0000", busy, car_enable_draw);
    else pass_cnt++;
  endtask

  task automatic test_chain();
    stage = 3'b001;
    tick(2);
    total_cnt++;
    if (car_initiate !== 1'b1) $display("FAIL initiate: car_initiate=%b expected 1", car_initiate);
    else pass_cnt++;
    start_pulse();
    total_cnt++;
    if (busy !== 1'b1 || car_delay_frames !== ROW_S0)
      $display("FAIL chain_latch: busy=%b delay=%h expected 1 %h", busy, car_delay_frames, ROW_S0);
    else pass_cnt++;
    serve_cars(16'h8421, 4, "chain");
  endtask

  task automatic test_skip();
    car_destroyed = 4'b0010;
    tick(1);
    car_destroyed  = 4'b0000;
    car_erase_done = 4'b0110;  // car 2 not destroyed yet: its erase is ignored
    tick(1);
    car_erase_done = 4'b0000;
    car_destroyed  = 4'b0100;
    tick(1);
    car_destroyed = 4'b0000;
    tick(1);
    total_cnt++;
    if (wave_done !== 1'b0) $display("FAIL skip_wave: wave_done=%b expected 0", wave_done);
    else pass_cnt++;
    start_pulse();
    serve_cars(16'h0841, 3, "skip");
  endtask

  task automatic test_wren();
    total_cnt++;
    if (err_flags !== 3'b000) $display("FAIL pre_conflict: err_flags=%b expected 000", err_flags);
    else pass_cnt++;
    car_coord_in  = {15'h4444, 15'h3333, 15'h2222, 15'h1111};
    car_colour_in = {9'h144, 9'h133, 9'h122, 9'h111};
    car_wren_in   = 4'b0110;
    tick(1);
    total_cnt++;
    if ({vga.wren, vga.coord, vga.colour} !== {1'b1, 15'h2222, 9'h122})
      $display("FAIL conflict_mux: wren=%b coord=%h colour=%h expected 1 2222 122",
               vga.wren, vga.coord, vga.colour);
    else pass_cnt++;
    total_cnt++;
    if (err_flags !== 3'b010) $display("FAIL conflict_flag: err_flags=%b expected 010", err_flags);
    else pass_cnt++;
    car_wren_in = 4'b1000;
    tick(1);
    total_cnt++;
    if ({vga.wren, vga.coord, vga.colour} !== {1'b1, 15'h4444, 9'h144})
      $display("FAIL single_mux: wren=%b coord=%h colour=%h expected 1 4444 144",
               vga.wren, vga.coord, vga.colour);
    else pass_cnt++;
    car_wren_in = 4'b0000;
    tick(1);
    total_cnt++;
    if ({vga.wren, vga.coord, vga.colour} !== 25'b0)
      $display("FAIL idle_mux: wren=%b coord=%h colour=%h expected 0 0 0",
               vga.wren, vga.coord, vga.colour);
    else pass_cnt++;
  endtask

  task automatic test_wave_done();
    car_destroyed = 4'b1111;
    tick(1);
    car_destroyed  = 4'b0000;
    car_erase_done = 4'b1111;
    tick(1);
    car_erase_done = 4'b0000;
    total_cnt++;
    if (wave_done !== 1'b1) $display("FAIL wave_done: wave_done=%b expected 1", wave_done);
    else pass_cnt++;
    car_game_over = 4'b0100;
    tick(1);
    car_game_over = 4'b0000;
    tick(1);
    total_cnt++;
    if (game_over_feedback !== 1'b1 || err_flags !== 3'b010)
      $display("FAIL sticky: game_over=%b err=%b expected 1 010", game_over_feedback, err_flags);
    else pass_cnt++;
    stage = 3'b000;
    tick(2);
    total_cnt++;
    if ({car_initiate, wave_done, game_over_feedback, err_flags} !== 6'b0)
      $display("FAIL clear: initiate=%b wave_done=%b game_over=%b err=%b expected all 0",
               car_initiate, wave_done, game_over_feedback, err_flags);
    else pass_cnt++;
  endtask

  task automatic test_timeout_overrun();
    stage = 3'b001;
    tick(2);
    start_pulse();
    wait_enable(4'b0001, "to_first");
    tick(5);
    start_frame = 1'b1;
    tick(1);
    start_frame = 1'b0;
    total_cnt++;
    if (err_flags !== 3'b100) $display("FAIL overrun: err_flags=%b expected 100", err_flags);
    else pass_cnt++;
    tick(9);  // 15 edges after the enable was seen: one short of the timeout
    total_cnt++;
    if (err_flags !== 3'b100) $display("FAIL timeout_early: err_flags=%b expected 100", err_flags);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (err_flags !== 3'b101) $display("FAIL timeout: err_flags=%b expected 101", err_flags);
    else pass_cnt++;
    serve_cars(16'h0842, 3, "after_timeout");
  endtask

  task automatic test_stage_change();
    start_pulse();
    wait_enable(4'b0001, "stg_first");
    stage = 3'b100;
    tick(1);
    total_cnt++;
    if (car_delay_frames !== ROW_S0)
      $display("FAIL stage_hold: car_delay_frames=%h expected %h", car_delay_frames, ROW_S0);
    else pass_cnt++;
    car_done = 4'b0001;
    tick(1);
    car_done = 4'b0000;
    serve_cars(16'h0842, 3, "stg_rest");
    total_cnt++;
    if (car_delay_frames !== ROW_S0)
      $display("FAIL stage_idle: car_delay_frames=%h expected %h", car_delay_frames, ROW_S0);
    else pass_cnt++;
    start_pulse();
    total_cnt++;
    if (car_delay_frames !== ROW_S2)
      $display("FAIL stage_new: car_delay_frames=%h expected %h", car_delay_frames, ROW_S2);
    else pass_cnt++;
    serve_cars(16'h8421, 4, "stg2");
  endtask

  task automatic test_reset_mid();
    int extra;
    start_pulse();
    wait_enable(4'b0001, "mid_first");
    tick(1);
    resetn = 1'b1;
    tick(1);
    total_cnt++;
    if ({car_initiate, car_enable_draw, frame_done, busy, wave_done,
         game_over_feedback, err_flags, vga.wren} !== 13'b0)
      $display("FAIL mid_reset: got %b expected all zero",
               {car_initiate, car_enable_draw, frame_done, busy, wave_done,
                game_over_feedback, err_flags, vga.wren});
    else pass_cnt++;
    total_cnt++;
    if (car_delay_frames !== ROW_DEF)
      $display("FAIL mid_reset_delay: car_delay_frames=%h expected %h", car_delay_frames, ROW_DEF);
    else pass_cnt++;
    resetn = 1'b0;
    extra  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (car_enable_draw != 4'b0) extra++;
    end
    total_cnt++;
    if (extra != 0) $display("FAIL no_repeat: %0d enable cycles after reset, expected 0", extra);
    else pass_cnt++;
  endtask

  initial begin
    resetn         = 1'b1;
    stage          = '0;
    start_frame    = 1'b0;
    car_destroyed  = '0;
    car_done       = '0;
    car_erase_done = '0;
    car_game_over  = '0;
    car_wren_in    = '0;
    car_coord_in   = '0;
    car_colour_in  = '0;
    test_reset();
    test_chain();
    test_skip();
    test_wren();
    test_wave_done();
    test_timeout_overrun();
    test_stage_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
